// File: rtl/trigger_readout_scheduler_pkg.sv
// Shared definitions for the trigger readout scheduler: default widths, FSM encoding
// and the layout of a request FIFO entry {block, first, pattern}.
package trigger_readout_scheduler_pkg;

  localparam int BLOCK_BITS_DEF = 9;
  localparam int NUM_L4_DEF     = 4;
  localparam int OFFSET_BITS    = 9;
  localparam int COUNT_BITS     = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EVENT   = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  // Pattern occupies the low bits, the first flag sits above it, the block on top.
  function automatic int entry_width(input int block_bits, input int num_l4);
    return block_bits + 1 + num_l4;
  endfunction

  function automatic int entry_first_bit(input int num_l4);
    return num_l4;
  endfunction

  function automatic int entry_block_lsb(input int num_l4);
    return num_l4 + 1;
  endfunction

endpackage

// File: rtl/trigger_readout_scheduler_fifo.sv
// readout_req_fifo: synchronous first-word-fall-through request FIFO with a free-entry count.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module readout_req_fifo #(
  parameter int WIDTH = 14,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      free_count
);

  localparam int         DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count == '0);
  assign full       = (count == DEPTH_V);
  assign free_count = DEPTH_V - count;
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign rd_data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trigger_readout_scheduler.sv
// Converts T1 block periods into absolute IRS block readout requests queued for the digitizer.
// Optional macro TRIG_READOUT_STATS_EN implements the event/drop statistics counters.
module trigger_readout_scheduler
  import trigger_readout_scheduler_pkg::*;
#(
  parameter int NUM_L4       = NUM_L4_DEF,
  parameter int BLOCK_BITS   = BLOCK_BITS_DEF,
  parameter int FIFO_AW      = 4,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   block_ce_i,
  input  logic [BLOCK_BITS-1:0]  wr_block_i,
  input  logic                   T1_i,
  input  logic [OFFSET_BITS-1:0] T1_offset_i,
  input  logic [NUM_L4-1:0]      l4_matched_i,
  input  logic [NUM_L4-1:0]      l4_new_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [BLOCK_BITS-1:0]  req_block_o,
  output logic                   req_first_o,
  output logic [NUM_L4-1:0]      req_pattern_o,
  output logic                   disable_o,
  output logic                   disable_ce_o,
  output logic                   overflow_o,
  output logic [COUNT_BITS-1:0]  event_count_o,
  output logic [COUNT_BITS-1:0]  drop_count_o
);

  localparam int WIDTH     = entry_width(BLOCK_BITS, NUM_L4);
  localparam int FIRST_BIT = entry_first_bit(NUM_L4);
  localparam int BLOCK_LSB = entry_block_lsb(NUM_L4);

  state_t                state, state_nxt;
  logic                  stg_valid, stg_t1, stg_first;
  logic [BLOCK_BITS-1:0] stg_block;
  logic [NUM_L4-1:0]     stg_pattern;
  logic                  push_req, push_ok, push_refused, discard_drop, drop;
  logic                  pop, fifo_empty, fifo_full;
  logic [WIDTH-1:0]      rd_data;
  logic [FIFO_AW:0]      free_count;

  // Inputs are captured on the block strobe; the FSM acts on them one clock later.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stg_valid   <= 1'b0;
      stg_t1      <= 1'b0;
      stg_first   <= 1'b0;
      stg_block   <= '0;
      stg_pattern <= '0;
    end else begin
      stg_valid <= block_ce_i;
      if (block_ce_i) begin
        stg_t1      <= T1_i;
        stg_first   <= |l4_new_i;
        stg_block   <= wr_block_i - BLOCK_BITS'(T1_offset_i);
        stg_pattern <= l4_matched_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    push_req     = stg_valid && stg_t1 && (stg_first || state == ST_EVENT);
    push_ok      = push_req && (!fifo_full || pop);
    push_refused = push_req && !push_ok;
    discard_drop = stg_valid && stg_t1 && !stg_first && state == ST_DISCARD;
    if (push_ok)
      state_nxt = ST_EVENT;
    else if (push_refused)
      state_nxt = ST_DISCARD;
    else if (stg_valid && !stg_t1 && state == ST_EVENT)
      state_nxt = ST_IDLE;
  end

  assign drop = push_refused || discard_drop;
  assign pop  = req_valid_o && req_ready_i;

  readout_req_fifo #(
    .WIDTH (WIDTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .push       (push_ok),
    .wr_data    ({stg_block, stg_first, stg_pattern}),
    .pop        (pop),
    .rd_data    (rd_data),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .free_count (free_count)
  );

  // Memory contents are undefined after reset, so the request fields read zero while idle.
  assign req_valid_o   = !fifo_empty;
  assign req_block_o   = req_valid_o ? rd_data[BLOCK_LSB +: BLOCK_BITS] : '0;
  assign req_first_o   = req_valid_o && rd_data[FIRST_BIT];
  assign req_pattern_o = req_valid_o ? rd_data[NUM_L4-1:0] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      disable_o    <= 1'b0;
      disable_ce_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      disable_o    <= (32'(free_count) <= AFULL_MARGIN);
      disable_ce_o <= block_ce_i;
      if (drop) overflow_o <= 1'b1;
    end
  end

`ifdef TRIG_READOUT_STATS_EN
  logic [COUNT_BITS-1:0] event_count, drop_count;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      event_count <= '0;
      drop_count  <= '0;
    end else begin
      if (push_ok && stg_first && event_count != '1) event_count <= event_count + 16'd1;
      if (drop && drop_count != '1)                  drop_count  <= drop_count + 16'd1;
    end
  end

  assign event_count_o = event_count;
  assign drop_count_o  = drop_count;
`else
  assign event_count_o = '0;
  assign drop_count_o  = '0;
`endif

endmodule
